// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer ramp generator.
// Holds the FSM state type, the vector width and the level/thermometer helpers.
package therm_pkg;

   localparam int WIDTH = 16;
   localparam logic [4:0] MAX_LEVEL = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   function automatic logic [4:0] sat_level(input logic [4:0] level);
      logic [4:0] r;
      if (level > MAX_LEVEL) begin
         r = MAX_LEVEL;
      end else begin
         r = level;
      end
      return r;
   endfunction

   // Level L fills the top L bits; bit 15 is always the first to set.
   function automatic logic [WIDTH-1:0] level_to_therm(input logic [4:0] level);
      logic [WIDTH-1:0] t;
      t = 16'h0000;
      for (int i = 0; i < WIDTH; i++) begin
         t[i] = ((i + int'(level)) >= WIDTH);
      end
      return t;
   endfunction

endpackage

// File: rtl/therm_classify.sv
// Combinational classifier for a thermometer word: all-ones, all-zero and
// legality (ones contiguous from bit 15 downward).
module therm_classify
   import therm_pkg::*;
(
   input  logic [WIDTH-1:0] vec,
   output logic             all_ones,
   output logic             all_zero,
   output logic             legal
);

   assign all_ones = (vec == 16'hFFFF);
   assign all_zero = (vec == 16'h0000);
   // A one directly below a zero is the only way to break the thermometer form.
   assign legal    = ((vec[WIDTH-2:0] & ~vec[WIDTH-1:1]) == 15'h0000);

endmodule

// File: rtl/therm_ramp_gen_chk.sv
// Assertion checker for therm_ramp_gen, present only when
// THERM_RAMP_GEN_CHECK_EN is defined.
`ifdef THERM_RAMP_GEN_CHECK_EN
module therm_ramp_gen_chk (
   input logic clk,
   input logic rst_n,
   input logic illegal
);

   a_never_illegal: assert property (@(posedge clk) disable iff (!rst_n) !illegal)
      else $error("therm_ramp_gen: non-thermometer word on vec");

endmodule
`endif

// File: rtl/therm_ramp_gen.sv
// Thermometer ramp generator: accepts a fill level and ramps vec toward it
// STEP bits per cycle. Optional checker: define THERM_RAMP_GEN_CHECK_EN.
module therm_ramp_gen
   import therm_pkg::*;
#(
   parameter int STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       in_level,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             all_ones,
   output logic             all_zero
`ifdef THERM_RAMP_GEN_CHECK_EN
   ,
   output logic             illegal
`endif
);

   localparam logic [4:0] STEP_W = 5'(STEP);

   state_e           state_r;
   state_e           state_nxt_s;
   logic [4:0]       level_r;
   logic [4:0]       level_nxt_s;
   logic [4:0]       target_r;
   logic [4:0]       target_nxt_s;
   logic [4:0]       sat_s;
   logic [WIDTH-1:0] vec_nxt_s;
   logic             ones_nxt_s;
   logic             zero_nxt_s;
   logic             legal_s;

   assign sat_s     = sat_level(in_level);
   assign vec_nxt_s = level_to_therm(level_nxt_s);

   // Next state, next level and target capture.
   always_comb begin
      state_nxt_s  = state_r;
      level_nxt_s  = level_r;
      target_nxt_s = target_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               target_nxt_s = sat_s;
               if (sat_s == level_r) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_RAMP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RAMP: begin
            if (target_r > level_r) begin
               if ((target_r - level_r) > STEP_W) begin
                  level_nxt_s = level_r + STEP_W;
               end else begin
                  level_nxt_s = target_r;
               end
            end else begin
               if ((level_r - target_r) > STEP_W) begin
                  level_nxt_s = level_r - STEP_W;
               end else begin
                  level_nxt_s = target_r;
               end
            end
            // Switch to HOLD on the same edge the final step lands.
            if (level_nxt_s == target_r) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_RAMP;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Flags are classified from the next vec so they update with it.
   therm_classify u_classify (
      .vec      (vec_nxt_s),
      .all_ones (ones_nxt_s),
      .all_zero (zero_nxt_s),
      .legal    (legal_s)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         level_r   <= 5'd0;
         target_r  <= 5'd0;
         vec       <= 16'h0000;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         all_ones  <= 1'b0;
         all_zero  <= 1'b1;
      end else begin
         state_r   <= state_nxt_s;
         level_r   <= level_nxt_s;
         target_r  <= target_nxt_s;
         vec       <= vec_nxt_s;
         out_valid <= (state_nxt_s == ST_HOLD);
         in_ready  <= (state_nxt_s == ST_IDLE);
         all_ones  <= ones_nxt_s;
         all_zero  <= zero_nxt_s;
      end
   end

`ifdef THERM_RAMP_GEN_CHECK_EN
   // Sticky illegal-word flag, aligned with the vec it describes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else begin
         illegal <= illegal | ~legal_s;
      end
   end

   therm_ramp_gen_chk u_chk (
      .clk     (clk),
      .rst_n   (rst_n),
      .illegal (illegal)
   );
`else
   logic unused_legal_s;
   assign unused_legal_s = legal_s;
`endif

endmodule

// File: tb/tb_therm_ramp_gen.sv
// Self-checking bench for therm_ramp_gen: one STEP=1 and one STEP=4 instance,
// directed table, reset-mid-ramp sequence and randomized transfers.
module tb_therm_ramp_gen;

   logic        clk;
   logic        rst_n;
   logic [4:0]  lvl  [2];
   logic        iv   [2];
   logic        ir   [2];
   logic [15:0] v    [2];
   logic        ov   [2];
   logic        ordy [2];
   logic        ao   [2];
   logic        az   [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cur [2];
   int stp [2];

   therm_ramp_gen #(.STEP(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_level(lvl[0]), .in_valid(iv[0]),
      .in_ready(ir[0]), .vec(v[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .all_ones(ao[0]), .all_zero(az[0])
   );

   therm_ramp_gen #(.STEP(4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_level(lvl[1]), .in_valid(iv[1]),
      .in_ready(ir[1]), .vec(v[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .all_ones(ao[1]), .all_zero(az[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference thermometer word: top L bits set.
   function automatic logic [15:0] therm(input int l);
      int x;
      x = ((1 << l) - 1) << (16 - l);
      return x[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input int k, input string tag, input logic [15:0] ev,
                           input logic eov, input logic eir);
      chk($sformatf("%s.vec[%0d]", tag, k), 32'(v[k]), 32'(ev));
      chk($sformatf("%s.out_valid[%0d]", tag, k), 32'(ov[k]), 32'(eov));
      chk($sformatf("%s.in_ready[%0d]", tag, k), 32'(ir[k]), 32'(eir));
      chk($sformatf("%s.all_ones[%0d]", tag, k), 32'(ao[k]), 32'(ev == 16'hFFFF));
      chk($sformatf("%s.all_zero[%0d]", tag, k), 32'(az[k]), 32'(ev == 16'h0000));
   endtask

   task automatic wait_ready(input int k);
      int waited;
      waited = 0;
      while (!ir[k] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      chk($sformatf("ready_wait[%0d]", k), 32'(ir[k]), 32'd1);
   endtask

   // One full transfer: accept, ramp, hold with out_ready low, release.
   task automatic xfer(input int k, input int req, input int hold);
      int tgt, d, ad, n, moved, l;
      tgt = (req > 16) ? 16 : req;
      d   = tgt - cur[k];
      ad  = (d < 0) ? -d : d;
      n   = (ad + stp[k] - 1) / stp[k];
      wait_ready(k);
      lvl[k] = 5'(req);
      iv[k]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[k]  = 1'b0;
      lvl[k] = 5'($urandom_range(0, 31));
      if (n == 0) begin
         chk_outs(k, "accept_eq", therm(tgt), 1'b1, 1'b0);
      end else begin
         chk_outs(k, "accept", therm(cur[k]), 1'b0, 1'b0);
      end
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         moved = (i * stp[k] < ad) ? i * stp[k] : ad;
         l = (d < 0) ? cur[k] - moved : cur[k] + moved;
         chk_outs(k, $sformatf("ramp%0d", i), therm(l), (i == n), 1'b0);
      end
      cur[k] = tgt;
      iv[k]  = 1'b1;
      lvl[k] = 5'($urandom_range(0, 31));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk_outs(k, "hold", therm(tgt), 1'b1, 1'b0);
      end
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      chk_outs(k, "release", therm(tgt), 1'b0, 1'b1);
   endtask

   typedef struct {
      int          k;
      int          req;
      int          hold;
      logic [15:0] exp_vec;
   } vec_t;

   vec_t tbl [12];

   initial begin
      stp[0] = 1;
      stp[1] = 4;
      cur[0] = 0;
      cur[1] = 0;
      for (int k = 0; k < 2; k++) begin
         lvl[k]  = 5'd0;
         iv[k]   = 1'b0;
         ordy[k] = 1'b0;
      end

      tbl[0]  = '{0, 12, 0, 16'hFFF0};
      tbl[1]  = '{1, 12, 0, 16'hFFF0};
      tbl[2]  = '{1,  0, 0, 16'h0000};
      tbl[3]  = '{0, 16, 0, 16'hFFFF};
      tbl[4]  = '{0, 25, 5, 16'hFFFF};
      tbl[5]  = '{0,  3, 2, 16'hE000};
      tbl[6]  = '{0,  3, 0, 16'hE000};
      tbl[7]  = '{1,  7, 1, 16'hFE00};
      tbl[8]  = '{1, 31, 0, 16'hFFFF};
      tbl[9]  = '{1,  1, 0, 16'h8000};
      tbl[10] = '{1,  1, 3, 16'h8000};
      tbl[11] = '{0,  0, 0, 16'h0000};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk_outs(k, "reset", 16'h0000, 1'b0, 1'b1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk_outs(k, "post_reset", 16'h0000, 1'b0, 1'b1);
      end

      for (int i = 0; i < 12; i++) begin
         xfer(tbl[i].k, tbl[i].req, tbl[i].hold);
         chk($sformatf("tbl%0d.vec", i), 32'(v[tbl[i].k]), 32'(tbl[i].exp_vec));
      end

      // Reset in the middle of a ramp toward level 8 on the STEP=1 instance.
      wait_ready(0);
      lvl[0] = 5'd8;
      iv[0]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk_outs(0, "mid_ramp", 16'hC000, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cur[0] = 0;
      cur[1] = 0;
      for (int k = 0; k < 2; k++) begin
         chk_outs(k, "ramp_reset", 16'h0000, 1'b0, 1'b1);
      end
      @(negedge clk);
      chk_outs(0, "idle_after_reset", 16'h0000, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
